// File: rtl/fetch_mem_pkg.sv
// Shared encodings and helpers for the instruction-fetch front end.
package fetch_mem_pkg;

    typedef enum logic [1:0] {
        AS_WORD = 2'b00,
        AS_4    = 2'b01,
        AS_8    = 2'b10,
        AS_16   = 2'b11
    } access_size_e;

    localparam logic [31:0] DEFAULT_START_ADDR = 32'h8002_0000;

    function automatic int unsigned burst_len(input logic [1:0] size);
        case (size)
            AS_4:    return 4;
            AS_8:    return 8;
            AS_16:   return 16;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_mem_subsystem_pc_gen.sv
// PC register and access-enable strobe; the PC only moves when the owner
// signals that the current fetch (single word or whole burst) is complete.
module pc_gen
    import fetch_mem_pkg::*;
#(
    parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        step_en_i,
    input  logic [31:0] step_i,
    output logic [31:0] pc_o,
    output logic        enable_o
);

    logic [31:0] pc_q, pc_d;
    logic        enable_q, enable_d;

    always_comb begin
        pc_d     = pc_q;
        enable_d = ~stall_i;
        if (enable_q && !stall_i && step_en_i) begin
            pc_d = pc_q + step_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= START_ADDR;
            enable_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            enable_q <= enable_d;
        end
    end

    assign pc_o     = pc_q;
    assign enable_o = enable_q;

endmodule

// File: rtl/fetch_mem_subsystem.sv
// Fetch front end: PC generator plus a byte-addressed big-endian memory
// with single-word or burst access.
module fetch_mem_subsystem
    import fetch_mem_pkg::*;
#(
    parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
    parameter int unsigned MEM_BYTES  = 1024,
    parameter logic [1:0]  FETCH_SIZE = AS_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        rw,
    input  logic [31:0] din,
    output logic [31:0] pc,
    output logic [1:0]  access_size,
    output logic        enable,
    output logic [31:0] dout,
    output logic        busy
);

    localparam int unsigned BURST_N       = burst_len(FETCH_SIZE);
    localparam int unsigned AW            = $clog2(MEM_BYTES);
    localparam logic [4:0]  LAST_BEAT     = 5'(BURST_N - 1);
    localparam logic [31:0] BURST_BYTES   = 32'(4 * BURST_N);
    localparam logic [31:0] LAST_WORD_OFF = 32'(MEM_BYTES - 4);

    logic [7:0]    mem_q [MEM_BYTES];
    logic [4:0]    beat_q, beat_d;
    logic          busy_q, busy_d;
    logic [31:0]   dout_q, dout_d;
    logic          access, last_beat, in_range;
    logic [31:0]   addr, off, rd_word;
    logic [AW-1:0] idx;

    // For single-word fetch the beat counter never leaves 0, so last_beat
    // is always set and the PC steps by 4 on every access.
    pc_gen #(
        .START_ADDR (START_ADDR)
    ) u_pc_gen (
        .clk       (clk),
        .rst_n     (reset),
        .stall_i   (stall),
        .step_en_i (last_beat),
        .step_i    (BURST_BYTES),
        .pc_o      (pc),
        .enable_o  (enable)
    );

    assign access    = enable & ~stall;
    assign last_beat = (beat_q == LAST_BEAT);
    assign addr      = pc + {25'd0, beat_q, 2'b00};
    assign off       = addr - START_ADDR;
    assign in_range  = (addr >= START_ADDR) && (off <= LAST_WORD_OFF);
    assign idx       = off[AW-1:0];
    assign rd_word   = {mem_q[idx], mem_q[idx + AW'(1)],
                        mem_q[idx + AW'(2)], mem_q[idx + AW'(3)]};

    always_comb begin
        beat_d = beat_q;
        busy_d = busy_q;
        dout_d = dout_q;
        if (access) begin
            if (last_beat) begin
                beat_d = '0;
                busy_d = 1'b0;
            end else begin
                beat_d = beat_q + 5'd1;
                busy_d = 1'b1;
            end
            if (!rw) begin
                dout_d = in_range ? rd_word : 32'h0000_0000;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
            busy_q <= 1'b0;
            dout_q <= '0;
        end else begin
            beat_q <= beat_d;
            busy_q <= busy_d;
            dout_q <= dout_d;
        end
    end

    // Program image survives reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (access && rw && in_range) begin
            mem_q[idx]          <= din[31:24];
            mem_q[idx + AW'(1)] <= din[23:16];
            mem_q[idx + AW'(2)] <= din[15:8];
            mem_q[idx + AW'(3)] <= din[7:0];
        end
    end

    assign dout        = dout_q;
    assign busy        = busy_q;
    assign access_size = FETCH_SIZE;

endmodule

// File: tb/tb_fetch_mem_subsystem.sv
// Scoreboard bench: a single-word and a 4-beat burst instance share stimulus
// and are checked against a byte-array reference model.
module tb_fetch_mem_subsystem;
    import fetch_mem_pkg::*;

    localparam logic [31:0] START = 32'h8002_0000;
    localparam int MEMB = 1024;

    logic        clk;
    logic        reset, stall, rw;
    logic [31:0] din;
    logic [31:0] pc_a, dout_a, pc_b, dout_b;
    logic [1:0]  as_a, as_b;
    logic        en_a, en_b, busy_a, busy_b;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [1:0][31:0] pc;
        logic [1:0][31:0] dout;
        logic [1:0]       en;
        logic [1:0]       busy;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_pc   [2];
    logic [31:0] m_dout [2];
    bit          m_en   [2];
    int          m_beat [2];
    int          m_n    [2] = '{1, 4};
    logic [7:0]  m_mem  [2][MEMB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_mem_subsystem #(.START_ADDR(START), .MEM_BYTES(MEMB), .FETCH_SIZE(2'b00)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .rw(rw), .din(din),
        .pc(pc_a), .access_size(as_a), .enable(en_a), .dout(dout_a), .busy(busy_a));

    fetch_mem_subsystem #(.START_ADDR(START), .MEM_BYTES(MEMB), .FETCH_SIZE(2'b01)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .rw(rw), .din(din),
        .pc(pc_b), .access_size(as_b), .enable(en_b), .dout(dout_b), .busy(busy_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference: what one rising edge does to instance i, from the behavioural rules.
    task automatic model_step(input int i);
        logic [31:0] addr;
        longint      off;
        if (!reset) begin
            m_pc[i]   = START;
            m_en[i]   = 1'b0;
            m_dout[i] = 32'h0;
            m_beat[i] = 0;
            return;
        end
        if (m_en[i] && !stall) begin
            addr = m_pc[i] + 32'(4 * m_beat[i]);
            off  = longint'(addr) - longint'(START);
            if (rw) begin
                if (off >= 0 && off + 3 < MEMB) begin
                    m_mem[i][off]   = din[31:24];
                    m_mem[i][off+1] = din[23:16];
                    m_mem[i][off+2] = din[15:8];
                    m_mem[i][off+3] = din[7:0];
                end
            end else begin
                if (off >= 0 && off + 3 < MEMB)
                    m_dout[i] = {m_mem[i][off], m_mem[i][off+1], m_mem[i][off+2], m_mem[i][off+3]};
                else
                    m_dout[i] = 32'h0;
            end
            if (m_beat[i] == m_n[i] - 1) begin
                m_beat[i] = 0;
                m_pc[i]   = m_pc[i] + 32'(4 * m_n[i]);
            end else begin
                m_beat[i] = m_beat[i] + 1;
            end
        end
        m_en[i] = !stall;
    endtask

    task automatic cycle(input bit r, input bit s, input bit w, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        reset = r;
        stall = s;
        rw    = w;
        din   = d;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            e.pc[i]   = m_pc[i];
            e.dout[i] = m_dout[i];
            e.en[i]   = m_en[i];
            e.busy[i] = (m_beat[i] != 0);
        end
        sb_q.push_back(e);
    endtask

    // Monitor: one expected snapshot per edge, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc_a",     pc_a,           e.pc[0]);
                chk("en_a",     32'(en_a),      32'(e.en[0]));
                chk("busy_a",   32'(busy_a),    32'(e.busy[0]));
                chk("dout_a",   dout_a,         e.dout[0]);
                chk("pc_b",     pc_b,           e.pc[1]);
                chk("en_b",     32'(en_b),      32'(e.en[1]));
                chk("busy_b",   32'(busy_b),    32'(e.busy[1]));
                chk("dout_b",   dout_b,         e.dout[1]);
            end
        end
    end

    initial begin : driver
        reset = 1'b0;
        stall = 1'b0;
        rw    = 1'b0;
        din   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < MEMB; k++) m_mem[i][k] = 8'h00;
            m_pc[i] = START; m_en[i] = 1'b0; m_dout[i] = 32'h0; m_beat[i] = 0;
        end

        // Reset held 3 cycles, then fill the whole memory (plus a few out-of-range writes).
        repeat (3) cycle(1'b0, 1'b0, 1'b1, $urandom);
        chk("access_size_a", 32'(as_a), 32'(2'b00));
        chk("access_size_b", 32'(as_b), 32'(2'b01));
        repeat (262) cycle(1'b1, 1'b0, 1'b1, $urandom);

        // Read everything back, running past the end so out-of-range reads return 0.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (262) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Load a 13-word image whose first word checks byte order.
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678);
        for (int k = 1; k < 13; k++) cycle(1'b1, 1'b0, 1'b1, $urandom);

        // Read the image back with a two-cycle stall while pc sits at +8.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (14) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random mix of reads, writes, stalls and occasional mid-burst resets.
        for (int n = 0; n < 800; n++) begin
            cycle($urandom_range(0, 63) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_mem_subsystem.md
Name: fetch_mem_subsystem

Overview:
- Instruction-fetch front end for the MIPS pipeline: a PC generator drives a byte-addressed, big-endian unified memory.
- The memory holds a program image loaded through the write port (rw=1). It then returns one 32-bit instruction word per cycle (rw=0) to the downstream decode stage.
- Stall and busy both freeze the PC.

Parameters:
- START_ADDR, 32'h8002_0000, reset PC and byte address mapped to memory offset 0.
- MEM_BYTES, 1024, memory depth in bytes; power of two, multiple of 4.
- FETCH_SIZE, 2'b00, access_size the fetch unit drives. 00 = 1 word, 01 = 4, 10 = 8, 11 = 16-word burst.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  1 = hold PC and suppress memory access this cycle.
- rw  in  1  memory direction: 1 = write din, 0 = read to dout.
- din  in  32  write data, big-endian; din[31:24] goes to the lowest byte address.
- pc  out  32  current fetch/memory byte address.
- access_size  out  2  driven constant FETCH_SIZE.
- enable  out  1  memory access strobe.
- dout  out  32  registered read data.
- busy  out  1  1 while a multi-word burst is in progress.

Behaviour:
- Reset asserted (reset=0, asynchronous): pc=START_ADDR, enable=0, dout=0, busy=0, burst counter=0. Memory contents are not cleared.
- First rising edge after reset deassertion: enable becomes 1. pc stays at START_ADDR for that edge.
- Each later edge with enable=1, stall=0 and busy=0: pc <= pc+4, 32-bit wrap-around.
- stall=1: pc holds and enable=0 on that edge. enable returns to 1 on the first edge with stall=0.
- Memory access occurs on a rising edge when enable=1. Access address is pc for a single word, or the burst beat address.
- Write (rw=1): bytes off..off+3 <= din[31:24], din[23:16], din[15:8], din[7:0], where off = addr - START_ADDR.
- Read (rw=0): dout <= {mem[off], mem[off+1], mem[off+2], mem[off+3]}. Read latency is 1 clock.
- dout holds its value when no read occurs.
- Out-of-range access (addr < START_ADDR, or off+3 >= MEM_BYTES): writes are ignored; reads return 32'h0000_0000.
- Unaligned address (addr[1:0] != 0): bytes are taken at off..off+3 as-is; there is no alignment trap.
- access_size 00: busy stays 0.
- Burst access (01/10/11), started by an enabled access with busy=0:
  - busy=1 from the next edge for N-1 cycles, where N = 4, 8 or 16.
  - Each beat accesses start+4*k, with the internal beat counter incrementing.
  - pc holds while busy=1, then advances by 4*N when the burst ends.
- rw is sampled per beat.
- Stall during a burst pauses the beat counter.
- Reset mid-burst aborts the burst immediately.
- rw toggling between cycles takes effect on the next enabled edge. A write followed by a read of the same address returns the new data.

Decomposition:
- Package fetch_mem_pkg holds:
  - access_size encodings (AS_WORD=2'b00, AS_4=2'b01, AS_8=2'b10, AS_16=2'b11);
  - a function returning burst length;
  - the default START_ADDR.
- One natural sub-module: pc_gen (PC register, enable, stall/busy hold). The memory array and burst logic stay in the top module.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, then release -> pc=32'h8002_0000, enable=0 and dout=0 during reset; enable=1 after the first edge; pc then steps 8002_0004, 8002_0008, ...
- Load then read back: rw=1 for 13 enabled cycles with din = image bytes {mem[k],mem[k+1],mem[k+2],mem[k+3]}. Reset, set rw=0, run 13 cycles -> dout equals the written words in order, one cycle after each pc.
- Endianness: write din=32'h1234_5678 at 8002_0000 -> bytes 12,34,56,78 at offsets 0..3; read returns 32'h1234_5678.
- Stall: stall=1 for 2 cycles at pc=8002_0008 -> pc holds, enable=0, dout unchanged; resumes 8002_000C.
- Out-of-range: read at START_ADDR+MEM_BYTES -> dout=0; a write there leaves offset 0 unchanged.
- Burst (FETCH_SIZE=2'b01): one access -> busy=1 for 3 cycles; dout sequence is words at +0, +4, +8, +C; pc then equals START_ADDR+16.
